// File: rtl/mem_dma_initiator.sv
// Word-copy DMA initiator on a PicoRV32-style native memory bus.
// Each word is one read then one write, separated by mandatory one-cycle idle gaps.
module mem_dma_initiator #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LEN_W          = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    output logic             mem_valid,
    output logic             mem_instr,
    input  logic             mem_ready,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [31:0]      mem_rdata,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_RGAP = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_WGAP = 3'd4;
    localparam logic [2:0] S_FIN  = 3'd5;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [2:0]       r_state;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [31:0]      r_data;
    logic [LEN_W-1:0] r_rem;
    logic [LEN_W-1:0] r_words;
    logic [TW-1:0]    r_tcnt;
    logic             r_err;
    logic             r_abort;

    logic w_in_xfer;
    logic w_timeout;
    logic w_abort;
    logic w_unused;

    assign w_in_xfer = (r_state == S_RD) || (r_state == S_WR);
    // Ready in the final allowed cycle still wins over the timeout.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_in_xfer && !mem_ready && (r_tcnt == TLAST);
    assign w_abort   = r_abort || abort;
    assign w_unused  = ^{src_addr[1:0], dst_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_data  <= '0;
            r_rem   <= '0;
            r_words <= '0;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            if (busy && abort) begin
                r_abort <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err   <= 1'b0;
                        r_words <= '0;
                        r_abort <= 1'b0;
                        if (len != '0) begin
                            r_src   <= {src_addr[31:2], 2'b00};
                            r_dst   <= {dst_addr[31:2], 2'b00};
                            r_rem   <= len;
                            r_tcnt  <= '0;
                            r_state <= S_RD;
                        end else begin
                            r_state <= S_FIN;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        r_data  <= mem_rdata;
                        r_src   <= r_src + 32'd4;
                        r_state <= S_RGAP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_RGAP: begin
                    // An aborted read is dropped here rather than written.
                    if (w_abort) begin
                        r_state <= S_FIN;
                    end else begin
                        r_tcnt  <= '0;
                        r_state <= S_WR;
                    end
                end
                S_WR: begin
                    if (mem_ready) begin
                        r_dst   <= r_dst + 32'd4;
                        r_words <= r_words + LEN_W'(1);
                        r_rem   <= r_rem - LEN_W'(1);
                        r_state <= S_WGAP;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_WGAP: begin
                    if ((r_rem == '0) || w_abort) begin
                        r_state <= S_FIN;
                    end else begin
                        r_tcnt  <= '0;
                        r_state <= S_RD;
                    end
                end
                S_FIN: begin
                    r_abort <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus outputs decode from state so reset removes them without a clock edge.
    assign mem_valid  = w_in_xfer;
    assign mem_instr  = 1'b0;
    assign mem_addr   = (r_state == S_RD) ? r_src : ((r_state == S_WR) ? r_dst : 32'd0);
    assign mem_wdata  = r_data;
    assign mem_wstrb  = (r_state == S_WR) ? 4'hF : 4'h0;
    assign busy       = (r_state == S_RD) || (r_state == S_RGAP) ||
                        (r_state == S_WR) || (r_state == S_WGAP);
    assign done       = (r_state == S_FIN);
    assign err        = r_err;
    assign words_done = r_words;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_dma_initiator.sv
// Bench for mem_dma_initiator: randomized-latency memory responder, reference copy
// model feeding expected-transaction queues, and a monitor that checks each bus handshake.
module tb_mem_dma_initiator;

    localparam int LEN_W = 16;
    localparam int TO    = 8;

    logic             clk;
    logic             resetn;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] words_done;
    logic             mem_valid;
    logic             mem_instr;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_rdata;
    logic [2:0]       dbg_state;

    mem_dma_initiator #(.TIMEOUT_CYCLES(TO), .LEN_W(LEN_W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .abort(abort), .busy(busy), .done(done),
        .err(err), .words_done(words_done), .mem_valid(mem_valid),
        .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ram[logic [31:0]];
    logic [31:0] model_ram[logic [31:0]];
    logic [64:0] exp_q[$];
    logic [LEN_W:0] exp_done_q[$];

    int lat_min  = 0;
    int lat_max  = 0;
    bit stall_rd = 1'b0;
    bit stall_wr = 1'b0;

    function automatic logic [31:0] def_word(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : def_word(a);
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_ram.exists(a) ? model_ram[a] : def_word(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        ram[a]       = d;
        model_ram[a] = d;
    endtask

    // Responder: ready follows valid after a per-transaction latency, drops after the handshake.
    initial begin
        int wait_cnt;
        int cur_lat;
        bit blocked;
        mem_ready = 1'b0;
        mem_rdata = '0;
        wait_cnt  = 0;
        cur_lat   = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
                mem_rdata = $urandom;
            end else if (mem_valid) begin
                if (wait_cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
                blocked = (mem_wstrb == 4'h0) ? stall_rd : stall_wr;
                if (!blocked && wait_cnt >= cur_lat) begin
                    mem_ready = 1'b1;
                    if (mem_wstrb == 4'hF) ram[mem_addr] = mem_wdata;
                    else mem_rdata = ram_rd(mem_addr);
                end else begin
                    wait_cnt++;
                    mem_rdata = $urandom;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every handshake and every done pulse is matched against the expected queues.
    initial begin
        logic [64:0]    e;
        logic [LEN_W:0] c;
        forever begin
            @(negedge clk);
            #1;
            if (resetn) begin
                if (!mem_valid) check("wstrb_idle", mem_wstrb, 4'h0);
                if (mem_valid && mem_ready) begin
                    check("mem_instr", mem_instr, 1'b0);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL tx_unexpected: got addr %0h wstrb %0h, expected no transaction", mem_addr, mem_wstrb);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_kind", mem_wstrb, e[64] ? 4'hF : 4'h0);
                        check("tx_addr", mem_addr, e[63:32]);
                        if (e[64]) check("tx_wdata", mem_wdata, e[31:0]);
                    end
                end
                if (done) begin
                    check("done_busy", busy, 1'b0);
                    if (exp_done_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL done_unexpected: got done=1 words=%0d, expected no done", words_done);
                    end else begin
                        c = exp_done_q.pop_front();
                        check("done_words", words_done, c[LEN_W-1:0]);
                        check("done_err", err, c[LEN_W]);
                    end
                end
            end
        end
    end

    // Reference copy: word i is read from src+4i and written to dst+4i, in order,
    // until len words or until the read of word abort_k has been made.
    task automatic model_cmd(input logic [31:0] s, input logic [31:0] d, input int n, input int abort_k);
        logic [31:0] sa;
        logic [31:0] da;
        logic [31:0] w;
        int nrd;
        int nwr;
        sa  = {s[31:2], 2'b00};
        da  = {d[31:2], 2'b00};
        nrd = (abort_k >= 0 && abort_k < n) ? abort_k + 1 : n;
        nwr = (abort_k >= 0 && abort_k < n) ? abort_k : n;
        for (int i = 0; i < nrd; i++) begin
            exp_q.push_back({1'b0, sa + 32'(4 * i), 32'd0});
            if (i < nwr) begin
                w = model_rd(sa + 32'(4 * i));
                model_ram[da + 32'(4 * i)] = w;
                exp_q.push_back({1'b1, da + 32'(4 * i), w});
            end
        end
        exp_done_q.push_back({1'b0, LEN_W'(nwr)});
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = LEN_W'(n);
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || exp_done_q.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        #2;
        check("cmd_complete", (k < budget), 1'b1);
        if (k >= budget) begin
            exp_q.delete();
            exp_done_q.delete();
        end
    endtask

    task automatic run_cmd(input logic [31:0] s, input logic [31:0] d, input int n);
        model_cmd(s, d, n, -1);
        pulse_start(s, d, n);
        wait_done(40 * n + 40);
    endtask

    initial begin
        int k;
        int cnt;
        logic [31:0] s;
        logic [31:0] d;
        resetn   = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_words", words_done, '0);
        check("rst_valid", mem_valid, 1'b0);
        check("rst_wstrb", mem_wstrb, 4'h0);
        check("rst_addr", mem_addr, 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Basic copy: ready one cycle after valid; done follows WGAP and FIN.
        lat_min = 1;
        lat_max = 1;
        for (int i = 0; i < 4; i++) preload(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
        model_cmd(32'h100, 32'h200, 4, -1);
        pulse_start(32'h100, 32'h200, 4);
        k = 1;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("basic_done_cycle", k, 25);
        wait_done(20);
        for (int i = 0; i < 4; i++) check("basic_ram", ram_rd(32'h200 + 32'(4 * i)), 32'hA0 + 32'(i));
        check("basic_err", err, 1'b0);

        // Zero length: done one cycle after start, no bus activity.
        exp_done_q.push_back('0);
        pulse_start(32'h100, 32'h300, 0);
        check("zero_done_cycle", done, 1'b1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cnt += int'(busy) + int'(mem_valid);
            @(negedge clk);
        end
        check("zero_no_activity", cnt, 0);
        wait_done(5);

        // Timeout on the first read.
        stall_rd = 1'b1;
        exp_done_q.push_back({1'b1, LEN_W'(0)});
        pulse_start(32'h700, 32'h800, 3);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cnt += int'(mem_valid);
            @(negedge clk);
        end
        check("timeout_valid_cycles", cnt, TO);
        wait_done(5);
        check("timeout_err_sticky", err, 1'b1);
        stall_rd = 1'b0;
        model_cmd(32'h700, 32'h800, 1, -1);
        pulse_start(32'h700, 32'h800, 1);
        #1;
        check("restart_err_clear", err, 1'b0);
        check("restart_words_clear", words_done, '0);
        wait_done(40);

        // Abort during the third word's read.
        model_cmd(32'h400, 32'h500, 10, 2);
        pulse_start(32'h400, 32'h500, 10);
        k = 0;
        while (!(mem_valid && mem_wstrb == 4'h0 && mem_addr == 32'h408) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("abort_reach_read", (k < 100), 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(40);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cnt += int'(mem_valid);
            @(negedge clk);
        end
        check("abort_no_more_valid", cnt, 0);
        check("abort_words", words_done, LEN_W'(2));

        // Address wrap from the top of memory.
        preload(32'hFFFF_FFFC, 32'h1234_5678);
        preload(32'h0000_0000, 32'h9ABC_DEF0);
        run_cmd(32'hFFFF_FFFE, 32'h600, 2);
        check("wrap_word0", ram_rd(32'h600), 32'h1234_5678);
        check("wrap_word1", ram_rd(32'h604), 32'h9ABC_DEF0);

        // Asynchronous reset inside a write valid window.
        stall_wr = 1'b1;
        exp_q.push_back({1'b0, 32'h900, 32'd0});
        pulse_start(32'h900, 32'hA00, 1);
        k = 0;
        while (!(mem_valid && mem_wstrb == 4'hF) && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("rst_reach_write", (k < 40), 1'b1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_valid", mem_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_wstrb", mem_wstrb, 4'h0);
        check("arst_done", done, 1'b0);
        check("arst_read_seen", exp_q.size(), 0);
        exp_q.delete();
        exp_done_q.delete();
        @(negedge clk);
        resetn   = 1'b1;
        stall_wr = 1'b0;
        run_cmd(32'h900, 32'hA00, 1);
        check("arst_restart_words", words_done, LEN_W'(1));

        // Randomized commands with random responder latency and unaligned addresses.
        lat_min = 0;
        lat_max = 3;
        for (int t = 0; t < 10; t++) begin
            s = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            d = 32'h2000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            run_cmd(s, d, $urandom_range(1, 6));
        end
        foreach (model_ram[a]) check("ram_final", ram_rd(a), model_ram[a]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
